// File: rtl/fram_pkg.sv
// Shared widths, opcodes and FSM encoding for the FRAM read responder.
// FRAM_FAST_READ_EN selects FAST READ (0x0B plus one dummy byte) instead of READ (0x03).
package fram_pkg;

    localparam int LEN_W  = 11;
    localparam int ADDR_W = 16;

    localparam logic [7:0] FRAM_OP_READ  = 8'h03;
    localparam logic [7:0] FRAM_OP_FREAD = 8'h0B;

`ifdef FRAM_FAST_READ_EN
    localparam bit FRAM_FAST = 1'b1;
`else
    localparam bit FRAM_FAST = 1'b0;
`endif

    localparam logic [7:0] FRAM_OPCODE = FRAM_FAST ? FRAM_OP_FREAD : FRAM_OP_READ;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
`ifdef FRAM_FAST_READ_EN
    localparam logic [2:0] S_DUMMY = 3'd5;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_CMD   = S_CMD,
        ST_ADDR  = S_ADDR,
        ST_DATA  = S_DATA,
`ifdef FRAM_FAST_READ_EN
        ST_DUMMY = S_DUMMY,
`endif
        ST_HOLD  = S_HOLD
    } fram_state_e;

endpackage

// File: rtl/fram_spi_reader_if.sv
// Request/response bundle between an init loader (master) and the FRAM reader (slave).
// Responses carry no backpressure: the master must take every valid byte.
interface fram_spi_reader_if;
    import fram_pkg::*;

    logic              fram_rden;
    logic [LEN_W-1:0]  fram_length;
    logic [ADDR_W-1:0] fram_addr;
    logic              fram_busy;
    logic              fram_rd_error;
    logic              init_fram_valid;
    logic              init_fram_last;
    logic [7:0]        init_fram_data;

    modport master (
        output fram_rden, fram_length, fram_addr,
        input  fram_busy, fram_rd_error, init_fram_valid, init_fram_last, init_fram_data
    );

    modport slave (
        input  fram_rden, fram_length, fram_addr,
        output fram_busy, fram_rd_error, init_fram_valid, init_fram_last, init_fram_data
    );

endinterface

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: one byte per 16*CLK_DIV cycles, first SCK rise CLK_DIV cycles after start.
// rx_done follows the 8th capture edge by one cycle; done marks the last half-period so a start can chain bytes gap-free.
module spi_byte_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       sys_clk,
    input  logic       glbl_rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       done,
    output logic       rx_done,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    logic       active;
    logic [7:0] div_cnt;
    logic [3:0] half_cnt;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic       tick;
    logic       rise;
    logic       load;

    assign tick = active && (div_cnt == 8'(CLK_DIV - 1));
    assign rise = tick && !sck;
    assign done = tick && sck && (half_cnt == 4'd15);
    assign load = start && (!active || done);

    always_ff @(posedge sys_clk or posedge glbl_rst) begin
        if (glbl_rst) begin
            active   <= 1'b0;
            div_cnt  <= 8'd0;
            half_cnt <= 4'd0;
            tx_sr    <= 8'd0;
            rx_sr    <= 8'd0;
            rx_byte  <= 8'd0;
            rx_done  <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (load) begin
                // Chained loads land on the final falling edge, so MOSI still only moves while SCK drops.
                active   <= 1'b1;
                div_cnt  <= 8'd0;
                half_cnt <= 4'd0;
                tx_sr    <= tx_byte;
                mosi     <= tx_byte[7];
                sck      <= 1'b0;
            end else if (tick) begin
                div_cnt  <= 8'd0;
                sck      <= ~sck;
                half_cnt <= half_cnt + 4'd1;
                if (rise) begin
                    rx_sr <= {rx_sr[6:0], miso};
                    if (half_cnt == 4'd14) begin
                        rx_byte <= {rx_sr[6:0], miso};
                        rx_done <= 1'b1;
                    end
                end else begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                    mosi  <= tx_sr[6];
                    if (half_cnt == 4'd15) begin
                        active <= 1'b0;
                        mosi   <= 1'b0;
                    end
                end
            end else if (active) begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/fram_spi_reader.sv
// FRAM read responder: one SPI READ burst per request (FAST READ + dummy byte when FRAM_FAST_READ_EN is defined).
// First byte (3+1)*16*CLK_DIV-1 cycles after CS_n falls; no upstream backpressure, requests while busy are dropped.
module fram_spi_reader
    import fram_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_HOLD = 4
) (
    input  logic              sys_clk,
    input  logic              glbl_rst,
    fram_spi_reader_if.slave  rd,
    output logic              fram_cs_n,
    output logic              fram_sck,
    output logic              fram_mosi,
    input  logic              fram_miso
);

    localparam logic [15:0] TAIL_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(CS_HOLD - 1);

    fram_state_e       state;
    fram_state_e       state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  byte_cnt;
    logic [LEN_W-1:0]  bytes_left;
    logic              addr_lo_sent;
    logic              tail;
    logic [15:0]       wait_cnt;
    logic              accept;

    logic       sh_start;
    logic [7:0] sh_tx;
    logic       sh_done;
    logic       sh_rx_done;
    logic [7:0] sh_rx_byte;

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .sys_clk  (sys_clk),
        .glbl_rst (glbl_rst),
        .start    (sh_start),
        .tx_byte  (sh_tx),
        .done     (sh_done),
        .rx_done  (sh_rx_done),
        .rx_byte  (sh_rx_byte),
        .sck      (fram_sck),
        .mosi     (fram_mosi),
        .miso     (fram_miso)
    );

    assign accept = rd.fram_rden && (rd.fram_length != '0);
    // With CLK_DIV=1 the byte's rx_done coincides with its done, before byte_cnt has been decremented.
    assign bytes_left = byte_cnt - LEN_W'(sh_rx_done);

    always_ff @(posedge sys_clk or posedge glbl_rst) begin
        if (glbl_rst) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sh_start  = 1'b0;
        sh_tx     = 8'h00;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    sh_start  = 1'b1;
                    sh_tx     = FRAM_OPCODE;
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (sh_done) begin
                    sh_start  = 1'b1;
                    sh_tx     = addr_q[15:8];
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (sh_done) begin
                    sh_start = 1'b1;
                    if (!addr_lo_sent) begin
                        sh_tx = addr_q[7:0];
                    end else begin
`ifdef FRAM_FAST_READ_EN
                        state_nxt = ST_DUMMY;
`else
                        state_nxt = ST_DATA;
`endif
                    end
                end
            end
`ifdef FRAM_FAST_READ_EN
            ST_DUMMY: begin
                if (sh_done) begin
                    sh_start  = 1'b1;
                    state_nxt = ST_DATA;
                end
            end
`endif
            ST_DATA: begin
                if (sh_done && (bytes_left != '0)) sh_start = 1'b1;
                if (tail && (wait_cnt == TAIL_LAST)) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (wait_cnt == HOLD_LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge glbl_rst) begin
        if (glbl_rst) begin
            fram_cs_n          <= 1'b1;
            rd.fram_busy       <= 1'b0;
            rd.fram_rd_error   <= 1'b0;
            rd.init_fram_valid <= 1'b0;
            rd.init_fram_last  <= 1'b0;
            rd.init_fram_data  <= 8'd0;
            addr_q             <= '0;
            byte_cnt           <= '0;
            addr_lo_sent       <= 1'b0;
            tail               <= 1'b0;
            wait_cnt           <= 16'd0;
        end else begin
            rd.fram_rd_error   <= 1'b0;
            rd.init_fram_valid <= 1'b0;
            rd.init_fram_last  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd.fram_rden && (rd.fram_length == '0)) begin
                        rd.fram_rd_error <= 1'b1;
                    end else if (accept) begin
                        addr_q       <= rd.fram_addr;
                        byte_cnt     <= rd.fram_length;
                        addr_lo_sent <= 1'b0;
                        rd.fram_busy <= 1'b1;
                        fram_cs_n    <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (sh_done) addr_lo_sent <= 1'b1;
                end
                ST_DATA: begin
                    if (sh_rx_done) begin
                        rd.init_fram_valid <= 1'b1;
                        rd.init_fram_data  <= sh_rx_byte;
                        rd.init_fram_last  <= (byte_cnt == LEN_W'(1));
                        byte_cnt           <= byte_cnt - LEN_W'(1);
                    end
                    // SCK is back low after the final byte; CS_n follows CLK_DIV cycles later.
                    if (sh_done && !sh_start) begin
                        tail     <= 1'b1;
                        wait_cnt <= 16'd0;
                    end else if (tail) begin
                        if (wait_cnt == TAIL_LAST) begin
                            tail      <= 1'b0;
                            fram_cs_n <= 1'b1;
                            wait_cnt  <= 16'd0;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (wait_cnt == HOLD_LAST) begin
                        rd.fram_busy <= 1'b0;
                        wait_cnt     <= 16'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fram_spi_reader.sv
// Bench for fram_spi_reader with a serial FRAM model; honours FRAM_FAST_READ_EN for header and latency.
// Expected bytes and MOSI headers are queued at request time and popped by a separate monitor.
module tb_fram_spi_reader;
    import fram_pkg::*;

    localparam int CLK_DIV  = 2;
    localparam int CS_HOLD  = 4;
    localparam int BYTE_CYC = 16 * CLK_DIV;
`ifdef FRAM_FAST_READ_EN
    localparam int          HDR_BITS = 32;
    localparam logic [31:0] HDR_MASK = 32'hFFFF_FFFF;
`else
    localparam int          HDR_BITS = 24;
    localparam logic [31:0] HDR_MASK = 32'h00FF_FFFF;
`endif
    localparam int HDR_BYTES = HDR_BITS / 8;

    logic sys_clk   = 1'b0;
    logic glbl_rst  = 1'b1;
    logic fram_miso = 1'b0;
    logic fram_cs_n, fram_sck, fram_mosi;

    fram_spi_reader_if rd_if();

    fram_spi_reader #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD)) dut (
        .sys_clk   (sys_clk),
        .glbl_rst  (glbl_rst),
        .rd        (rd_if),
        .fram_cs_n (fram_cs_n),
        .fram_sck  (fram_sck),
        .fram_mosi (fram_mosi),
        .fram_miso (fram_miso)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  exp_q[$];
    logic [31:0] exp_hdr_q[$];
    logic [31:0] got_hdr_q[$];

    int cyc = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, busy_fall_cyc = 0;
    int prev_valid_cyc = 0, first_lat = 0, vcount = 0, cs_falls = 0;
    logic cs_prev = 1'b1, busy_prev = 1'b0;

    logic [31:0] m_sr   = 32'd0;
    int          m_bits = 0;
    logic [15:0] m_addr = 16'd0;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return (a == 16'h0400) ? 8'hA5 : a[7:0];
    endfunction

    function automatic logic [31:0] hdr_word(input logic [15:0] a);
`ifdef FRAM_FAST_READ_EN
        return {FRAM_OPCODE, a, 8'h00};
`else
        return {8'h00, FRAM_OPCODE, a};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // FRAM model: shifts in opcode/address on SCK rise, drives data MSB first on SCK fall.
    initial forever begin
        @(posedge fram_sck or posedge fram_cs_n);
        if (fram_cs_n) begin
            m_bits = 0;
        end else begin
            m_sr = {m_sr[30:0], fram_mosi};
            m_bits++;
            if (m_bits == 24) m_addr = m_sr[15:0];
            if (m_bits == HDR_BITS) got_hdr_q.push_back(m_sr & HDR_MASK);
        end
    end

    initial forever begin
        @(negedge fram_sck);
        if (!fram_cs_n && m_bits >= HDR_BITS) begin
            int idx;
            logic [7:0] b;
            idx = m_bits - HDR_BITS;
            b = mem_byte(m_addr + 16'(idx / 8));
            fram_miso = b[7 - (idx % 8)];
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a byte or the model completes a header.
    initial forever begin
        @(negedge sys_clk);
        cyc++;
        if (cs_prev && !fram_cs_n) begin
            cs_fall_cyc = cyc;
            cs_falls++;
            vcount = 0;
        end
        if (!cs_prev && fram_cs_n) cs_rise_cyc = cyc;
        if (busy_prev && !rd_if.fram_busy) busy_fall_cyc = cyc;
        cs_prev   = fram_cs_n;
        busy_prev = rd_if.fram_busy;
        if (rd_if.init_fram_last && !rd_if.init_fram_valid) begin
            checks++;
            failures++;
            $display("FAIL last_without_valid: last=1 valid=0 at cycle %0d", cyc);
        end
        if (rd_if.init_fram_valid) begin
            if (vcount == 0) first_lat = cyc - cs_fall_cyc;
            else check("valid_spacing", 32'(cyc - prev_valid_cyc), 32'(BYTE_CYC));
            prev_valid_cyc = cyc;
            vcount++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: data 0x%0h last %0b with nothing expected",
                         rd_if.init_fram_data, rd_if.init_fram_last);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("valid_data", 32'(rd_if.init_fram_data), 32'(e[7:0]));
                check("valid_last", 32'(rd_if.init_fram_last), 32'(e[8]));
            end
        end
        while (got_hdr_q.size() != 0) begin
            logic [31:0] g;
            g = got_hdr_q.pop_front();
            if (exp_hdr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_header: got 0x%0h with nothing expected", g);
            end else begin
                check("mosi_header", g, exp_hdr_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [10:0] len, input int n_exp);
        rd_if.fram_rden   = 1'b1;
        rd_if.fram_addr   = a;
        rd_if.fram_length = len;
        if (n_exp > 0) exp_hdr_q.push_back(hdr_word(a));
        for (int i = 0; i < n_exp; i++)
            exp_q.push_back({i == int'(len) - 1, mem_byte(a + 16'(i))});
        @(negedge sys_clk);
        rd_if.fram_rden = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        repeat (3) @(negedge sys_clk);
        while ((rd_if.fram_busy || exp_q.size() != 0) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
        repeat (8) @(negedge sys_clk);
    endtask

    initial begin
        int n;
        int n0;
        rd_if.fram_rden   = 1'b0;
        rd_if.fram_addr   = 16'd0;
        rd_if.fram_length = 11'd0;
        repeat (2) @(negedge sys_clk);
        check("rst_cs_n",  32'(fram_cs_n), 32'd1);
        check("rst_sck",   32'(fram_sck), 32'd0);
        check("rst_mosi",  32'(fram_mosi), 32'd0);
        check("rst_busy",  32'(rd_if.fram_busy), 32'd0);
        check("rst_err",   32'(rd_if.fram_rd_error), 32'd0);
        check("rst_valid", 32'(rd_if.init_fram_valid), 32'd0);
        check("rst_last",  32'(rd_if.init_fram_last), 32'd0);
        check("rst_data",  32'(rd_if.init_fram_data), 32'd0);
        glbl_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Single byte
        issue(16'h0400, 11'd1, 1);
        check("single_busy_up", 32'(rd_if.fram_busy), 32'd1);
        check("single_cs_low",  32'(fram_cs_n), 32'd0);
        wait_idle("single_done", 2000);
        check("single_count", 32'(vcount), 32'd1);
        check_range("single_latency", first_lat,
                    (HDR_BYTES + 1) * BYTE_CYC - 1, (HDR_BYTES + 1) * BYTE_CYC + 1);
        check_range("busy_after_cs_rise", busy_fall_cyc - cs_rise_cyc, CS_HOLD, CS_HOLD + 2);

        // 900-byte burst from address 0
        issue(16'h0000, 11'd900, 900);
        wait_idle("burst_done", 40000);
        check("burst_count", 32'(vcount), 32'd900);

        // Zero length
        n0 = cs_falls;
        issue(16'h0055, 11'd0, 0);
        check("zero_err_pulse", 32'(rd_if.fram_rd_error), 32'd1);
        check("zero_busy",      32'(rd_if.fram_busy), 32'd0);
        check("zero_cs_n",      32'(fram_cs_n), 32'd1);
        @(negedge sys_clk);
        check("zero_err_clear", 32'(rd_if.fram_rd_error), 32'd0);
        repeat (20) @(negedge sys_clk);
        check("zero_no_cs", 32'(cs_falls), 32'(n0));
        check("zero_busy_later", 32'(rd_if.fram_busy), 32'd0);

        // Request while busy is dropped
        issue(16'h0010, 11'd3, 3);
        repeat (60) @(negedge sys_clk);
        check("collide_busy", 32'(rd_if.fram_busy), 32'd1);
        issue(16'h1234, 11'd5, 0);
        wait_idle("collide_done", 3000);
        check("collide_count", 32'(vcount), 32'd3);
        check("collide_one_cs", 32'(cs_falls), 32'(n0 + 1));

        // Address wrap handled by the FRAM
        issue(16'hFFFE, 11'd4, 4);
        wait_idle("wrap_done", 3000);
        check("wrap_count", 32'(vcount), 32'd4);

        // Reset after the third byte of a ten-byte read
        issue(16'h0020, 11'd10, 3);
        n = 0;
        while (vcount < 3 && n < 2000) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        check("rstmid_reached", 32'(n < 2000), 32'd1);
        glbl_rst = 1'b1;
        #1;
        check("rstmid_cs_n",  32'(fram_cs_n), 32'd1);
        check("rstmid_valid", 32'(rd_if.init_fram_valid), 32'd0);
        check("rstmid_sck",   32'(fram_sck), 32'd0);
        repeat (3) @(negedge sys_clk);
        glbl_rst = 1'b0;
        repeat (200) @(negedge sys_clk);
        check("rstmid_count", 32'(vcount), 32'd3);
        issue(16'h0100, 11'd2, 2);
        wait_idle("post_rst_done", 3000);
        check("post_rst_count", 32'(vcount), 32'd2);

        check("exp_q_drained",   32'(exp_q.size()), 32'd0);
        check("hdr_q_drained",   32'(exp_hdr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
